// File: rtl/mem_ctrl_seq_pkg.sv
// rtl/mem_ctrl_seq_pkg.sv - opcodes, control-word bit indices and memory-state helper
package mem_ctrl_seq_pkg;

  localparam int CW_MIN = 17;

  typedef enum logic [2:0] {
    OP_ILL = 3'b000,
    OP_AND = 3'b001,
    OP_ADD = 3'b010,
    OP_LDA = 3'b011,
    OP_STA = 3'b100,
    OP_BUN = 3'b101,
    OP_BSA = 3'b110,
    OP_ISZ = 3'b111
  } opcode_e;

  localparam int AR_LD_PC  = 0;
  localparam int IR_LD_MEM = 1;
  localparam int PC_INC    = 2;
  localparam int AR_LD_IR  = 3;
  localparam int AR_LD_MEM = 4;
  localparam int DR_LD_MEM = 5;
  localparam int AC_AND    = 6;
  localparam int AC_ADD    = 7;
  localparam int AC_LD_DR  = 8;
  localparam int MEM_WR_AC = 9;
  localparam int PC_LD_AR  = 10;
  localparam int MEM_WR_PC = 11;
  localparam int AR_INC    = 12;
  localparam int DR_INC    = 13;
  localparam int MEM_WR_DR = 14;
  localparam int MEM_RD    = 15;
  localparam int SC_CLR    = 16;

  // A word touching memory must wait for mem_ready before the chain advances.
  function automatic logic is_mem_word(input logic [CW_MIN-1:0] w);
    return w[MEM_RD] | w[MEM_WR_AC] | w[MEM_WR_PC] | w[MEM_WR_DR];
  endfunction

endpackage

// File: rtl/mem_ctrl_seq_seq_timer.sv
// rtl/mem_ctrl_seq_seq_timer.sv - one-hot timing chain with hold and clear
module seq_timer #(
  parameter int NT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          clr,
  output logic [NT-1:0] t_state
);

  localparam logic [NT-1:0] T0 = {{(NT-1){1'b0}}, 1'b1};

  // The last state wraps to T0 so a stray walk off the end cannot lose the token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_state <= T0;
    end else if (!hold) begin
      if (clr || t_state[NT-1]) begin
        t_state <= T0;
      end else begin
        t_state <= t_state << 1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_seq.sv
// rtl/mem_ctrl_seq.sv - memory-reference sequencer with ready stall and variable length
// ISZ support is compiled in with MEM_CTRL_SEQ_ISZ_EN; otherwise 111 decodes as illegal.
module mem_ctrl_seq
  import mem_ctrl_seq_pkg::*;
#(
  parameter int CW = 17,
  parameter int NT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    opcode,
  input  logic          i_bit,
  input  logic          mem_ready,
  input  logic          dr_zero,
  output logic [CW-1:0] control_mem,
  output logic [NT-1:0] t_state,
  output logic          instr_done,
  output logic          illegal_op
);

  opcode_e             op_q;
  logic                i_q;
  logic [CW_MIN-1:0]   w;
  logic                ill;
  logic                hold;

  seq_timer #(.NT(NT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .clr     (w[SC_CLR]),
    .t_state (t_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= OP_ILL;
      i_q  <= 1'b0;
    end else if (t_state[2]) begin
      op_q <= opcode_e'(opcode);
      i_q  <= i_bit;
    end
  end

`ifndef MEM_CTRL_SEQ_ISZ_EN
  logic unused_dr_zero;
  assign unused_dr_zero = dr_zero;
`endif

  always_comb begin
    w   = '0;
    ill = 1'b0;
    if (t_state[0]) begin
      w[AR_LD_PC] = en;
    end else if (t_state[1]) begin
      w[MEM_RD]    = 1'b1;
      w[IR_LD_MEM] = 1'b1;
      w[PC_INC]    = 1'b1;
    end else if (t_state[2]) begin
      w[AR_LD_IR] = 1'b1;
    end else if (t_state[3]) begin
      w[MEM_RD]    = i_q;
      w[AR_LD_MEM] = i_q;
    end else if (t_state[4]) begin
      case (op_q)
        OP_AND, OP_ADD, OP_LDA: begin
          w[MEM_RD]    = 1'b1;
          w[DR_LD_MEM] = 1'b1;
        end
        OP_STA: begin
          w[MEM_WR_AC] = 1'b1;
          w[SC_CLR]    = 1'b1;
        end
        OP_BUN: begin
          w[PC_LD_AR] = 1'b1;
          w[SC_CLR]   = 1'b1;
        end
        OP_BSA: begin
          w[MEM_WR_PC] = 1'b1;
          w[AR_INC]    = 1'b1;
        end
`ifdef MEM_CTRL_SEQ_ISZ_EN
        OP_ISZ: begin
          w[MEM_RD]    = 1'b1;
          w[DR_LD_MEM] = 1'b1;
        end
`endif
        default: begin
          w[SC_CLR] = 1'b1;
          ill       = 1'b1;
        end
      endcase
    end else if (t_state[5]) begin
      case (op_q)
        OP_AND:  begin w[AC_AND]   = 1'b1; w[SC_CLR] = 1'b1; end
        OP_ADD:  begin w[AC_ADD]   = 1'b1; w[SC_CLR] = 1'b1; end
        OP_LDA:  begin w[AC_LD_DR] = 1'b1; w[SC_CLR] = 1'b1; end
        OP_BSA:  begin w[PC_LD_AR] = 1'b1; w[SC_CLR] = 1'b1; end
`ifdef MEM_CTRL_SEQ_ISZ_EN
        OP_ISZ:  w[DR_INC] = 1'b1;
`endif
        default: w = '0;
      endcase
`ifdef MEM_CTRL_SEQ_ISZ_EN
    end else if (t_state[6] && op_q == OP_ISZ) begin
      w[MEM_WR_DR] = 1'b1;
      w[SC_CLR]    = 1'b1;
      w[PC_INC]    = dr_zero;
`endif
    end
    if (reset) begin
      w   = '0;
      ill = 1'b0;
    end
  end

  assign hold = (t_state[0] & ~en) | (is_mem_word(w) & ~mem_ready);

  always_comb begin
    control_mem               = '0;
    control_mem[CW_MIN-1:0]   = w;
  end

  assign instr_done = w[SC_CLR] & ~hold;
  assign illegal_op = ill;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// tb/tb_mem_ctrl_seq.sv - randomized self-checking bench for mem_ctrl_seq
module tb_mem_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  opcode;
  logic        i_bit;
  logic        mem_ready;
  logic        dr_zero;
  logic [16:0] control_mem;
  logic [7:0]  t_state;
  logic        instr_done;
  logic        illegal_op;

  int compared   = 0;
  int mismatched = 0;
  logic [16:0] exp_q[$];

`ifdef MEM_CTRL_SEQ_ISZ_EN
  localparam bit ISZ_ON = 1'b1;
`else
  localparam bit ISZ_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_ctrl_seq #(.CW(17), .NT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .opcode      (opcode),
    .i_bit       (i_bit),
    .mem_ready   (mem_ready),
    .dr_zero     (dr_zero),
    .control_mem (control_mem),
    .t_state     (t_state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  // Full word sequence of one instruction, written straight from the opcode table.
  function automatic void build_seq(input logic [2:0] op, input logic ib, input logic dz);
    exp_q = {17'h00001, 17'h08006, 17'h00008, ib ? 17'h08010 : 17'h00000};
    case (op)
      3'b001: begin exp_q.push_back(17'h08020); exp_q.push_back(17'h10040); end
      3'b010: begin exp_q.push_back(17'h08020); exp_q.push_back(17'h10080); end
      3'b011: begin exp_q.push_back(17'h08020); exp_q.push_back(17'h10100); end
      3'b100: exp_q.push_back(17'h10200);
      3'b101: exp_q.push_back(17'h10400);
      3'b110: begin exp_q.push_back(17'h01800); exp_q.push_back(17'h10400); end
      3'b111: begin
        if (ISZ_ON) begin
          exp_q.push_back(17'h08020);
          exp_q.push_back(17'h02000);
          exp_q.push_back(dz ? 17'h14004 : 17'h14000);
        end else begin
          exp_q.push_back(17'h10000);
        end
      end
      default: exp_q.push_back(17'h10000);
    endcase
  endfunction

  task automatic run_instr(input logic [2:0] op, input logic ib, input logic dz,
                           input int stall_k, input int stall_n, input int pct,
                           output int cycles);
    int k = 0;
    int stalled = 0;
    logic stall;
    logic ill;
    logic [16:0] w;
    build_seq(op, ib, dz);
    ill = (op == 3'b000) || (op == 3'b111 && !ISZ_ON);
    cycles = 0;
    while (k < exp_q.size()) begin
      if (cycles >= 100) begin
        compared++;
        mismatched++;
        $display("FAIL timeout op=%0d: stuck at step %0d, t_state %h", op, k, t_state);
        break;
      end
      w       = exp_q[k];
      en      = (k == 0) ? 1'b1 : 1'($urandom_range(1));
      opcode  = (k == 2) ? op : 3'($urandom_range(7));
      i_bit   = (k == 2) ? ib : 1'($urandom_range(1));
      dr_zero = dz;
      if (k == stall_k && stalled < stall_n) begin
        mem_ready = 1'b0;
        stalled++;
      end else begin
        mem_ready = ($urandom_range(99) >= pct);
      end
      stall = ((w & 17'h0CA00) != 17'h0) && !mem_ready;
      #1;
      compared += 4;
      if (control_mem !== w) begin
        mismatched++;
        $display("FAIL word op=%0d step=%0d: got %h want %h", op, k, control_mem, w);
      end
      if (t_state !== 8'(1 << k)) begin
        mismatched++;
        $display("FAIL t_state op=%0d step=%0d: got %h want %h", op, k, t_state, 8'(1 << k));
      end
      if (instr_done !== (!stall && k == exp_q.size() - 1)) begin
        mismatched++;
        $display("FAIL instr_done op=%0d step=%0d: got %b want %b", op, k, instr_done,
                 (!stall && k == exp_q.size() - 1));
      end
      if (illegal_op !== (ill && k == 4)) begin
        mismatched++;
        $display("FAIL illegal_op op=%0d step=%0d: got %b want %b", op, k, illegal_op, (ill && k == 4));
      end
      @(posedge clk);
      #1;
      cycles++;
      if (!stall) k++;
    end
    compared++;
    if (t_state !== 8'h01) begin
      mismatched++;
      $display("FAIL end_state op=%0d: got %h want 01", op, t_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; opcode = 3'b010; i_bit = 1'b0; mem_ready = 1'b1; dr_zero = 1'b0;
    @(posedge clk);
    #1;
    compared += 4;
    if (t_state !== 8'h01) begin mismatched++; $display("FAIL reset_t_state: got %h want 01", t_state); end
    if (control_mem !== 17'h0) begin mismatched++; $display("FAIL reset_word: got %h want 0", control_mem); end
    if (instr_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", instr_done); end
    if (illegal_op !== 1'b0) begin mismatched++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    int cyc;
    int want;
    for (int op = 0; op < 8; op++) begin
      case (op)
        1, 2, 3, 6: want = 6;
        4, 5:       want = 5;
        7:          want = ISZ_ON ? 7 : 5;
        default:    want = 5;
      endcase
      run_instr(3'(op), 1'($urandom_range(1)), 1'b0, -1, 0, 0, cyc);
      compared++;
      if (cyc !== want) begin
        mismatched++;
        $display("FAIL latency op=%0d: got %0d cycles want %0d", op, cyc, want);
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    run_instr(3'b011, 1'b1, 1'b0, 3, 2, 0, cyc);
    compared++;
    if (cyc !== 8) begin mismatched++; $display("FAIL stall_lda: got %0d cycles want 8", cyc); end
    run_instr(3'b100, 1'b0, 1'b0, 4, 3, 0, cyc);
    compared++;
    if (cyc !== 8) begin mismatched++; $display("FAIL stall_sta: got %0d cycles want 8", cyc); end
  endtask

  task automatic test_isz();
    int cyc;
    run_instr(3'b111, 1'b0, 1'b1, -1, 0, 0, cyc);
    run_instr(3'b111, 1'b1, 1'b0, 6, 2, 0, cyc);
    compared++;
    if (cyc !== (ISZ_ON ? 9 : 5)) begin
      mismatched++;
      $display("FAIL isz_stall: got %0d cycles want %0d", cyc, ISZ_ON ? 9 : 5);
    end
  endtask

  task automatic test_idle();
    int n;
    en = 1'b0;
    n = $urandom_range(3, 6);
    for (int c = 0; c < n; c++) begin
      opcode = 3'($urandom_range(7)); mem_ready = 1'($urandom_range(1));
      @(posedge clk);
      #1;
      compared += 3;
      if (t_state !== 8'h01) begin mismatched++; $display("FAIL idle_t_state: got %h want 01", t_state); end
      if (control_mem !== 17'h0) begin mismatched++; $display("FAIL idle_word: got %h want 0", control_mem); end
      if (instr_done !== 1'b0) begin mismatched++; $display("FAIL idle_done: got %b want 0", instr_done); end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; opcode = 3'b010; i_bit = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      en = 1'b0;
    end
    compared++;
    if (control_mem !== 17'h08020) begin mismatched++; $display("FAIL mid_t4_word: got %h want 08020", control_mem); end
    reset = 1'b1;
    #1;
    compared += 2;
    if (control_mem !== 17'h0) begin mismatched++; $display("FAIL mid_reset_word: got %h want 0", control_mem); end
    if (t_state !== 8'h01) begin mismatched++; $display("FAIL mid_reset_t_state: got %h want 01", t_state); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_idle();
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 40; n++) begin
      run_instr(3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)), -1, 0, 30, cyc);
      if ($urandom_range(3) == 0) test_idle();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_isz();
    test_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
